// File: rtl/cordic_div_param.sv
// Signed fixed-point divider built on linear (vectoring) CORDIC.
// Operands are captured on a start pulse when idle. One load cycle and ITER
// iteration cycles follow, then a finish cycle writes the quotient and pulses done.
// Divide-by-zero and out-of-range ratios saturate and raise ovf.
module cordic_div_param #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 14,
   parameter int ITER  = 15,
   parameter int GUARD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cordic_div_en,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] division,
   output logic [WIDTH-1:0] quotient,
   output logic             cordic_div_flag,
   output logic             busy,
   output logic             ovf
);

   localparam int YW = WIDTH + GUARD + 2;
   localparam int ZW = WIDTH + 2;
   localparam int CW = $clog2(ITER + 1);
   localparam int SH = WIDTH - FRAC - 1;
   localparam int BW = WIDTH + 1 + SH;
   localparam logic [ZW-1:0]    W0      = ZW'(1) << FRAC;
   localparam logic [ZW-1:0]    LIM     = ZW'(1) << (WIDTH - 1);
   localparam logic [CW-1:0]    LAST    = CW'(ITER - 1);
   localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIN} state_t;

   state_t state, state_n;

   logic [WIDTH-1:0]     a_reg, b_reg;
   logic                 sa, zero_div, zero_num, big;
   logic signed [YW-1:0] x, y;
   logic signed [ZW-1:0] z;
   logic [CW-1:0]        cnt;

   logic signed [WIDTH:0] a_ext, b_ext;
   logic [WIDTH:0]        ma, mb;
   logic signed [YW-1:0]  xs, y_step;
   logic [ZW-1:0]         w, z_mag;
   logic signed [ZW-1:0]  z_step;
   logic [WIDTH-1:0]      q_lin;
   logic                  sat;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next-state: start only from idle; the finish cycle returns to idle
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (cordic_div_en) state_n = S_LOAD;
         S_LOAD:  state_n = S_ITER;
         S_ITER:  if (cnt == LAST) state_n = S_FIN;
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Magnitudes, one CORDIC step and final quotient selection
   always_comb begin
      a_ext  = {a_reg[WIDTH-1], a_reg};
      b_ext  = {b_reg[WIDTH-1], b_reg};
      // WIDTH+1 bits so that the most negative operand has a representable magnitude
      ma     = a_reg[WIDTH-1] ? -a_ext : a_ext;
      mb     = b_reg[WIDTH-1] ? -b_ext : b_ext;
      xs     = x >>> cnt;
      // Weight 2^(FRAC-i) shifts out to zero once i exceeds FRAC
      w      = W0 >> cnt;
      y_step = y[YW-1] ? (y + xs) : (y - xs);
      z_step = y[YW-1] ? (z - signed'(w)) : (z + signed'(w));
      z_mag  = z[ZW-1] ? -z : z;
      sat    = big | (z_mag >= LIM);
      q_lin  = sa ? -z[WIDTH-1:0] : z[WIDTH-1:0];
   end

   // Operand capture, iteration datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg           <= '0;
         b_reg           <= '0;
         sa              <= 1'b0;
         zero_div        <= 1'b0;
         zero_num        <= 1'b0;
         big             <= 1'b0;
         x               <= '0;
         y               <= '0;
         z               <= '0;
         cnt             <= '0;
         quotient        <= '0;
         cordic_div_flag <= 1'b0;
         busy            <= 1'b0;
         ovf             <= 1'b0;
      end else begin
         cordic_div_flag <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cordic_div_en) begin
                  a_reg <= dividend;
                  b_reg <= division;
                  busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               sa       <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
               zero_div <= (mb == '0);
               zero_num <= (ma == '0);
               big      <= (BW'(ma) >= (BW'(mb) << SH));
               y        <= signed'(YW'(ma) << GUARD);
               x        <= signed'(YW'(mb) << GUARD);
               z        <= '0;
               cnt      <= '0;
            end
            S_ITER: begin
               y   <= y_step;
               z   <= z_step;
               cnt <= cnt + CW'(1);
            end
            S_FIN: begin
               cordic_div_flag <= 1'b1;
               busy            <= 1'b0;
               if (zero_div) begin
                  // Divide-by-zero follows the dividend sign; 0/0 gives MAX
                  quotient <= a_reg[WIDTH-1] ? Q_MIN : Q_MAX;
                  ovf      <= 1'b1;
               end else if (zero_num) begin
                  quotient <= '0;
                  ovf      <= 1'b0;
               end else if (sat) begin
                  quotient <= sa ? Q_MIN : Q_MAX;
                  ovf      <= 1'b1;
               end else begin
                  quotient <= q_lin;
                  ovf      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
